// File: rtl/palette_bank_lut.sv
// Banked color palette: a clear sequence zeroes every entry after reset, then
// pixel indices are translated to {R,G,B} with a fixed two-cycle latency.
module palette_bank_lut #(
  parameter int IDX_W      = 5,
  parameter int CH_W       = 8,
  parameter int BANKS      = 2,
  parameter int TRANSP_IDX = 0,
  localparam int BK_W      = $clog2(BANKS)
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               wr_en,
  input  logic [BK_W-1:0]    wr_bank,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [3*CH_W-1:0]  wr_rgb,
  input  logic [BK_W-1:0]    bank_sel,
  input  logic               frame_start,
  input  logic               rd_valid_in,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic               init_busy,
  output logic [BK_W-1:0]    active_bank,
  output logic               rd_valid_out,
  output logic [CH_W-1:0]    Red,
  output logic [CH_W-1:0]    Green,
  output logic [CH_W-1:0]    Blue,
  output logic               transparent
);

  localparam int DEPTH   = 1 << IDX_W;
  localparam int ENTRIES = BANKS * DEPTH;
  localparam int ADDR_W  = BK_W + IDX_W;
  localparam int RGB_W   = 3 * CH_W;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_init_busy;
  logic               w_run;
  logic               w_init_last;
  logic [ADDR_W-1:0]  r_init_cnt;

  logic [RGB_W-1:0]   r_mem [ENTRIES];
  logic               w_mem_we;
  logic [ADDR_W-1:0]  w_mem_addr;
  logic [RGB_W-1:0]   w_mem_wdata;

  logic [BK_W-1:0]    r_active_bank;
  logic               r_s1_valid, r_s2_valid;
  logic [RGB_W-1:0]   r_s1_rgb, r_s2_rgb;
  logic               r_s1_transp, r_s2_transp;
  logic               r_valid_out;
  logic [CH_W-1:0]    r_red, r_green, r_blue;
  logic               r_transp;

  assign w_init_last = (r_init_cnt == ADDR_W'(ENTRIES - 1));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= ST_INIT;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (w_init_last) w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    w_init_busy = 1'b0;
    w_run       = 1'b0;
    case (r_state)
      ST_INIT: w_init_busy = 1'b1;
      ST_RUN:  w_run       = 1'b1;
      default: w_init_busy = 1'b1;
    endcase
  end

  // Clear order is bank-major, index-minor because the address is {bank, idx}.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)         r_init_cnt <= '0;
    else if (w_init_busy) r_init_cnt <= r_init_cnt + ADDR_W'(1);
  end

  always_comb begin
    w_mem_we    = w_init_busy | (w_run & wr_en);
    w_mem_addr  = w_init_busy ? r_init_cnt : {wr_bank, wr_idx};
    w_mem_wdata = w_init_busy ? '0 : wr_rgb;
  end

  always_ff @(posedge Clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                r_active_bank <= '0;
    else if (w_run && frame_start) r_active_bank <= bank_sel;
  end

  // Lookup handshake: rd_valid_in has no back-pressure; each request accepted
  // at edge N is presented on rd_valid_out after edge N+2, one per cycle.
  // The array is read at edge N, so a same-edge write is not yet visible.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_valid_out <= 1'b0;
      r_red       <= '0;
      r_green     <= '0;
      r_blue      <= '0;
      r_transp    <= 1'b0;
    end else begin
      r_s1_valid  <= w_run & rd_valid_in;
      r_s2_valid  <= r_s1_valid;
      r_valid_out <= r_s2_valid;
      if (r_s2_valid) begin
        r_red    <= r_s2_rgb[3*CH_W-1:2*CH_W];
        r_green  <= r_s2_rgb[2*CH_W-1:CH_W];
        r_blue   <= r_s2_rgb[CH_W-1:0];
        r_transp <= r_s2_transp;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (rd_valid_in) begin
      r_s1_rgb    <= r_mem[{r_active_bank, rd_idx}];
      r_s1_transp <= (rd_idx == IDX_W'(TRANSP_IDX));
    end
    if (r_s1_valid) begin
      r_s2_rgb    <= r_s1_rgb;
      r_s2_transp <= r_s1_transp;
    end
  end

  assign init_busy    = w_init_busy;
  assign active_bank  = r_active_bank;
  assign rd_valid_out = r_valid_out;
  assign Red          = r_red;
  assign Green        = r_green;
  assign Blue         = r_blue;
  assign transparent  = r_transp;

endmodule

// File: tb/tb_palette_bank_lut.sv
// Directed bench for palette_bank_lut: stimulus pushes expected lookups into a
// queue, and an independent monitor checks each rd_valid_out result in order.
module tb_palette_bank_lut;

  localparam int IDX_W = 5;
  localparam int CH_W  = 8;
  localparam int BK_W  = 1;
  localparam int EXP_W = 1 + 3 * CH_W;

  logic               Clk = 1'b0;
  logic               Reset_n;
  logic               wr_en;
  logic [BK_W-1:0]    wr_bank;
  logic [IDX_W-1:0]   wr_idx;
  logic [3*CH_W-1:0]  wr_rgb;
  logic [BK_W-1:0]    bank_sel;
  logic               frame_start;
  logic               rd_valid_in;
  logic [IDX_W-1:0]   rd_idx;
  logic               init_busy;
  logic [BK_W-1:0]    active_bank;
  logic               rd_valid_out;
  logic [CH_W-1:0]    Red, Green, Blue;
  logic               transparent;

  logic [EXP_W-1:0]   exp_q[$];
  logic [EXP_W-1:0]   exp_e;
  int                 n_checks = 0;
  int                 n_fail   = 0;

  palette_bank_lut #(.IDX_W(IDX_W), .CH_W(CH_W), .BANKS(2), .TRANSP_IDX(0)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .wr_en(wr_en), .wr_bank(wr_bank), .wr_idx(wr_idx),
    .wr_rgb(wr_rgb), .bank_sel(bank_sel), .frame_start(frame_start),
    .rd_valid_in(rd_valid_in), .rd_idx(rd_idx), .init_busy(init_busy),
    .active_bank(active_bank), .rd_valid_out(rd_valid_out), .Red(Red),
    .Green(Green), .Blue(Blue), .transparent(transparent)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // monitor
  always @(negedge Clk) begin
    if (rd_valid_out) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(rd_valid_out), 32'd0);
      end else begin
        exp_e = exp_q.pop_front();
        check("lookup", 32'({transparent, Red, Green, Blue}), 32'(exp_e));
      end
    end
  end

  // driver tasks
  task automatic do_write(input logic [BK_W-1:0] b, input logic [IDX_W-1:0] i,
                          input logic [3*CH_W-1:0] rgb);
    wr_en = 1'b1; wr_bank = b; wr_idx = i; wr_rgb = rgb;
    @(posedge Clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [IDX_W-1:0] i, input logic [EXP_W-1:0] e);
    rd_valid_in = 1'b1; rd_idx = i;
    exp_q.push_back(e);
    @(posedge Clk); #1;
    rd_valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  // Releases reset with writes/reads/frame_start all active; they must be ignored.
  task automatic release_and_check_init();
    int  cnt  = 0;
    bit  done = 1'b0;
    wr_en = 1'b1; wr_bank = '0; wr_idx = 5'd7; wr_rgb = 24'hFFFFFF;
    rd_valid_in = 1'b1; rd_idx = 5'd7; frame_start = 1'b1; bank_sel = 1'b1;
    @(posedge Clk); #2;
    Reset_n = 1'b1;
    while (!done && cnt < 200) begin
      @(negedge Clk);
      if (init_busy) cnt++;
      else done = 1'b1;
    end
    wr_en = 1'b0; rd_valid_in = 1'b0; frame_start = 1'b0; bank_sel = '0;
    check("init_cycles", 32'(cnt), 32'd64);
    check("active_bank_after_init", 32'(active_bank), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_init_busy"}, 32'(init_busy), 32'd1);
    check({tag, "_active_bank"}, 32'(active_bank), 32'd0);
    check({tag, "_rd_valid_out"}, 32'(rd_valid_out), 32'd0);
    check({tag, "_rgb"}, 32'({Red, Green, Blue}), 32'd0);
    check({tag, "_transparent"}, 32'(transparent), 32'd0);
  endtask

  initial begin
    Reset_n = 1'b0; wr_en = 1'b0; wr_bank = '0; wr_idx = '0; wr_rgb = '0;
    bank_sel = '0; frame_start = 1'b0; rd_valid_in = 1'b0; rd_idx = '0;
    #12;
    check_reset_outputs("por");
    release_and_check_init();

    // cleared contents, and the write attempted during INIT was dropped
    do_read(5'd9, 25'h0_000000);
    do_read(5'd7, 25'h0_000000);
    idle(4);

    // write then two-cycle latency on a single lookup
    do_write(1'b0, 5'd3, 24'hE2007E);
    rd_valid_in = 1'b1; rd_idx = 5'd3;
    exp_q.push_back(25'h0_E2007E);
    @(posedge Clk); #1;
    rd_valid_in = 1'b0;
    check("lat_edge_n", 32'(rd_valid_out), 32'd0);
    @(posedge Clk); #1;
    check("lat_edge_n1", 32'(rd_valid_out), 32'd0);
    @(posedge Clk); #1;
    check("lat_edge_n2", 32'(rd_valid_out), 32'd1);
    idle(2);

    // bank_sel without frame_start is ignored; frame_start loads it
    do_write(1'b1, 5'd3, 24'h4E51CA);
    bank_sel = 1'b1;
    idle(3);
    check("bank_no_frame", 32'(active_bank), 32'd0);
    do_read(5'd3, 25'h0_E2007E);
    frame_start = 1'b1;
    @(posedge Clk); #1;
    frame_start = 1'b0;
    check("bank_frame", 32'(active_bank), 32'd1);
    do_read(5'd3, 25'h0_4E51CA);

    // bank switch on the same edge as a request: request keeps the old bank
    bank_sel = 1'b0; frame_start = 1'b1;
    rd_valid_in = 1'b1; rd_idx = 5'd3;
    exp_q.push_back(25'h0_4E51CA);
    @(posedge Clk); #1;
    frame_start = 1'b0; rd_valid_in = 1'b0;
    do_read(5'd3, 25'h0_E2007E);
    check("bank_back_to_0", 32'(active_bank), 32'd0);
    idle(3);

    // same-cycle write and read returns pre-write data
    wr_en = 1'b1; wr_bank = 1'b0; wr_idx = 5'd5; wr_rgb = 24'hFCD90C;
    rd_valid_in = 1'b1; rd_idx = 5'd5;
    exp_q.push_back(25'h0_000000);
    @(posedge Clk); #1;
    wr_en = 1'b0; rd_valid_in = 1'b0;
    do_read(5'd5, 25'h0_FCD90C);
    idle(3);

    // back-to-back sweep; only index 0 is transparent, whatever its color
    do_write(1'b0, 5'd0, 24'h123456);
    for (int i = 0; i < 32; i++) begin
      logic [EXP_W-1:0] e;
      case (i)
        0:       e = 25'h1_123456;
        3:       e = 25'h0_E2007E;
        5:       e = 25'h0_FCD90C;
        default: e = 25'h0_000000;
      endcase
      do_read(5'(i), e);
    end
    idle(4);
    check("sweep_drained", 32'(exp_q.size()), 32'd0);

    // reset with two lookups in flight
    bank_sel = 1'b1; frame_start = 1'b1;
    @(posedge Clk); #1;
    frame_start = 1'b0;
    do_read(5'd3, 25'h0_4E51CA);
    idle(4);
    rd_valid_in = 1'b1; rd_idx = 5'd5;
    @(posedge Clk); #1;
    rd_idx = 5'd3;
    @(posedge Clk); #1;
    rd_valid_in = 1'b0;
    Reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    idle(3);
    check("rst_held_valid", 32'(rd_valid_out), 32'd0);
    release_and_check_init();
    do_read(5'd3, 25'h0_000000);
    do_read(5'd0, 25'h1_000000);

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) idle(1);
    check("final_drained", 32'(exp_q.size()), 32'd0);
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/palette_bank_lut.md
PALETTE_BANK_LUT -- requirements
Module: palette_bank_lut

Interface
REQ-001 SHALL have parameter IDX_W, default 5, color-index width; the palette depth is 2^IDX_W entries per bank.
REQ-002 SHALL have parameter CH_W, default 8, per-channel color width.
REQ-003 SHALL have parameter BANKS, default 2, number of palette banks (power of two, >=2); BK_W = log2(BANKS).
REQ-004 SHALL have parameter TRANSP_IDX, default 0, the index flagged as transparent.
REQ-005 SHALL have port Clk  in  1  sole clock; all state changes on the rising edge.
REQ-006 SHALL have port Reset_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port wr_en  in  1  palette write strobe.
REQ-008 SHALL have port wr_bank  in  BK_W  bank targeted by the write.
REQ-009 SHALL have port wr_idx  in  IDX_W  entry targeted by the write.
REQ-010 SHALL have port wr_rgb  in  3*CH_W  write data {R,G,B}, with R in the MSBs.
REQ-011 SHALL have port bank_sel  in  BK_W  requested display bank.
REQ-012 SHALL have port frame_start  in  1  one-cycle frame-boundary pulse.
REQ-013 SHALL have port rd_valid_in  in  1  pixel lookup request.
REQ-014 SHALL have port rd_idx  in  IDX_W  pixel color index.
REQ-015 SHALL have port init_busy  out  1  high while the clear sequence runs.
REQ-016 SHALL have port active_bank  out  BK_W  bank currently used for lookups.
REQ-017 SHALL have port rd_valid_out  out  1  lookup result valid.
REQ-018 SHALL have ports Red, Green, Blue  out  CH_W each  looked-up color.
REQ-019 SHALL have port transparent  out  1  result index equals TRANSP_IDX.

Function
REQ-020 SHALL hold BANKS x 2^IDX_W entries of 3*CH_W bits in internal storage.
REQ-021 SHALL implement a two-state FSM, INIT and RUN; leaving reset enters INIT.
REQ-022 SHALL, in INIT, write zero to one entry per cycle using an internal counter (bank-major, index-minor) and assert init_busy.
REQ-023 SHALL move from INIT to RUN in the cycle after the last entry (counter = BANKS*2^IDX_W-1) is cleared, so INIT lasts exactly BANKS*2^IDX_W cycles.
REQ-024 SHALL ignore wr_en, rd_valid_in and frame_start in INIT; rd_valid_out stays 0.
REQ-025 SHALL, in RUN, write wr_rgb to entry (wr_bank, wr_idx) on a Clk edge where wr_en=1.
REQ-026 SHALL have a read latency of exactly 2 cycles: a request at edge N yields rd_valid_out=1 and data after edge N+2, fully pipelined at one lookup per cycle.
REQ-027 SHALL pipeline rd_valid_out together with the data; with rd_valid_out=0, Red/Green/Blue/transparent hold their previous values.
REQ-028 SHALL perform each lookup in the active_bank value sampled at request time; a later bank change does not affect requests already in flight.
REQ-029 SHALL load active_bank from bank_sel only on an edge where frame_start=1; bank_sel changes at other times are ignored.
REQ-030 SHALL, on a write and read to the same bank/index in the same cycle, return the old (pre-write) data; the new value is seen by requests from the next cycle on.
REQ-031 SHALL allow writes to any bank, the active bank included, with no stall.
REQ-032 SHALL assert transparent with the result when the requested index equals TRANSP_IDX, regardless of the stored color.

Reset
REQ-033 SHALL, while Reset_n=0, asynchronously force: FSM=INIT, init counter=0, init_busy=1, active_bank=0, rd_valid_out=0, Red=Green=Blue=0, transparent=0, and clear the pipeline valid bits.
REQ-034 SHALL, on reset asserted mid-INIT or mid-RUN, abort all in-flight lookups (no rd_valid_out) and restart the full clear after release.
REQ-035 SHALL leave storage contents undefined during reset; they are defined only after INIT completes.

Verification
REQ-036 SHALL be covered by: release reset with defaults -> init_busy high for exactly 64 cycles, then low; read of any index -> 0,0,0.
REQ-037 SHALL be covered by: write bank0 idx3 = 0xE2007E, request idx3 at cycle N -> rd_valid_out at N+2 with R=E2 G=00 B=7E, transparent=0.
REQ-038 SHALL be covered by: write bank1 idx3 = 0x4E51CA, bank_sel=1 without frame_start -> lookup still returns bank0 data; pulse frame_start -> next lookup returns 4E,51,CA.
REQ-039 SHALL be covered by: same-cycle write idx5 = 0xFCD90C and read idx5 -> old value returned; read on the next cycle -> FC,D9,0C.
REQ-040 SHALL be covered by: back-to-back requests idx 0..31, one per cycle -> 32 consecutive valid results in order; only idx0 has transparent=1.
REQ-041 SHALL be covered by: Reset_n pulsed low with two lookups in flight -> outputs 0 immediately, no rd_valid_out, init_busy high, and INIT re-runs for a full 64 cycles.
